// File: rtl/keypad_emulator_if.sv
// Key-code producer handshake into the keypad emulator.
// Latency: none, wires only.
// Backpressure: producer holds key_valid/key_in until key_ready is high at a clock edge.
interface keypad_emulator_if;
    logic [3:0] key_in;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_in, output key_valid, input key_ready);
    modport slave  (input key_in, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// Replays queued key codes as 4x4 matrix presses, answering the scanner's col drive on fila.
// Latency: a push into an empty queue is pressed after the next edge; HOLD clocks pressed, GAP clocks released.
// Backpressure: key_ready drops when the queue is full; key_valid while full is ignored.
module keypad_emulator #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1000000,
    parameter int GAP_CYCLES  = 500000,
    parameter int CNT_W       = 24,
    parameter bit ACT_LOW     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    keypad_emulator_if.slave       key,
    input  logic [3:0]             col,
    output logic [3:0]             fila,
    output logic                   pressed,
    output logic [3:0]             key_cur,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int               PW       = $clog2(DEPTH);
    localparam logic [PW:0]      FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       IDLE_LVL = {4{ACT_LOW}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;
    logic             cnt_zero;
    logic             col_hit;

    // ready is a pure function of occupancy so there is no path from key_valid
    assign key.key_ready = (fifo_count != FULL_CNT);
    assign push          = key.key_valid & key.key_ready;
    assign pop           = (state == S_IDLE) && (fifo_count != '0);
    assign cnt_zero      = (cnt == '0);

    // Queue storage; entries are only read when counted valid, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= key.key_in;
        end
    end

    // Queue pointers (wrap modulo DEPTH) and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state: take a key when one is queued, then hold, then release
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fifo_count != '0) state_nxt = S_PRESS;
            S_PRESS: if (cnt_zero)         state_nxt = S_GAP;
            S_GAP:   if (cnt_zero)         state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    // Hold/gap counter and latched key code; counter stops at zero, never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            key_cur <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        key_cur <= mem[rd_ptr];
                        cnt     <= HOLD_LD;
                    end
                end
                S_PRESS: cnt <= cnt_zero ? GAP_LD : cnt - 1'b1;
                S_GAP:   if (!cnt_zero) cnt <= cnt - 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    // Outputs: the selected row follows the selected column combinationally,
    // like a closed switch; other column bits are ignored
    always_comb begin
        pressed = (state == S_PRESS);
        busy    = (state != S_IDLE) || (fifo_count != '0);
        col_hit = (col[key_cur[1:0]] != ACT_LOW);
        fila    = IDLE_LVL;
        if (pressed && col_hit) begin
            fila[key_cur[3:2]] = ~ACT_LOW;
        end
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: directed tables, corner sequences and random traffic vs a timing model.
// Latency: n/a.
// Backpressure: producer tasks hold key_valid until key_ready is seen.
module tb_keypad_emulator;
    localparam int HOLD  = 8;
    localparam int GAP   = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0] col;
        logic [3:0] fila;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_emulator_if kif_a();
    keypad_emulator_if kif_b();

    logic [3:0] col_a, col_b, fila_a, fila_b, key_cur_a, key_cur_b;
    logic       pressed_a, pressed_b, busy_a, busy_b;
    logic [2:0] cnt_a, cnt_b;

    keypad_emulator #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
                      .CNT_W(24), .ACT_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .key(kif_a), .col(col_a), .fila(fila_a),
        .pressed(pressed_a), .key_cur(key_cur_a), .busy(busy_a), .fifo_count(cnt_a)
    );

    keypad_emulator #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
                      .CNT_W(24), .ACT_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .key(kif_b), .col(col_b), .fila(fila_b),
        .pressed(pressed_b), .key_cur(key_cur_b), .busy(busy_b), .fifo_count(cnt_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of codes plus the edge index at which the
    // current key was taken. Press window = HOLD edges, busy window = HOLD+GAP,
    // next key may be taken HOLD+GAP+1 edges after the previous one.
    bit [3:0] mq[$];
    int       t_edge  = 0;
    int       start_e = 0;
    bit       has_cur = 1'b0;
    bit [3:0] m_cur   = 4'h0;

    always @(posedge clk or negedge rst) begin
        bit can_push;
        if (!rst) begin
            mq.delete();
            has_cur = 1'b0;
            m_cur   = 4'h0;
        end else begin
            t_edge++;
            can_push = (mq.size() < DEPTH);
            if (mq.size() > 0 && (!has_cur || (t_edge - start_e) >= HOLD + GAP + 1)) begin
                m_cur   = mq.pop_front();
                has_cur = 1'b1;
                start_e = t_edge;
            end
            if (kif_a.key_valid && can_push) mq.push_back(kif_a.key_in);
        end
    end

    bit mon_en = 1'b0;
    always @(negedge clk) begin
        logic       ep, eb;
        logic [3:0] ef;
        if (mon_en) begin
            ep = has_cur && ((t_edge - start_e) < HOLD);
            eb = (mq.size() != 0) || (has_cur && ((t_edge - start_e) < HOLD + GAP));
            ef = 4'hF;
            if (ep && col_a[m_cur[1:0]] == 1'b0) ef[m_cur[3:2]] = 1'b0;
            chk("m_pressed", pressed_a, ep);
            chk("m_busy", busy_a, eb);
            chk("m_fila", fila_a, ef);
            chk("m_key_cur", key_cur_a, m_cur);
            chk("m_fifo_count", cnt_a, mq.size());
            chk("m_key_ready", kif_a.key_ready, mq.size() < DEPTH);
        end
    end

    // Record order of replayed keys and the length of each press
    bit [3:0] rec_keys[$];
    int       rec_hi[$];
    int       hi_run = 0;
    logic     prev_p = 1'b0;
    always @(negedge clk) begin
        if (pressed_a) hi_run++;
        if (pressed_a && !prev_p) rec_keys.push_back(key_cur_a);
        if (!pressed_a && prev_p) rec_hi.push_back(hi_run);
        if (!pressed_a) hi_run = 0;
        prev_p = pressed_a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [3:0] k);
        int n = 0;
        kif_a.key_in    = k;
        kif_a.key_valid = 1'b1;
        while (!kif_a.key_ready && n < 100) begin
            tick();
            n++;
        end
        chk("push_ready", kif_a.key_ready, 1'b1);
        tick();
        kif_a.key_valid = 1'b0;
    endtask

    task automatic wait_idle_a(input int maxc);
        int n = 0;
        while (busy_a && n < maxc) begin
            tick();
            n++;
        end
        chk("idle_reached", busy_a, 1'b0);
    endtask

    vec_t t2[8];
    vec_t t6[8];

    initial begin
        t2[0] = '{4'b1110, 4'b1111};
        t2[1] = '{4'b1101, 4'b1111};
        t2[2] = '{4'b1011, 4'b1101};
        t2[3] = '{4'b0111, 4'b1111};
        t2[4] = '{4'b1011, 4'b1101};
        t2[5] = '{4'b0011, 4'b1101};
        t2[6] = '{4'b1111, 4'b1111};
        t2[7] = '{4'b0000, 4'b1101};
        t6[0] = '{4'b1000, 4'b1000};
        t6[1] = '{4'b0100, 4'b0000};
        t6[2] = '{4'b1100, 4'b1000};
        t6[3] = '{4'b0111, 4'b0000};
        t6[4] = '{4'b1111, 4'b1000};
        t6[5] = '{4'b0000, 4'b0000};
        t6[6] = '{4'b1000, 4'b1000};
        t6[7] = '{4'b0001, 4'b0000};

        kif_a.key_valid = 1'b0; kif_a.key_in = 4'h0;
        kif_b.key_valid = 1'b0; kif_b.key_in = 4'h0;
        col_a = 4'b1110; col_b = 4'b0001;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        chk("rst_fila", fila_a, 4'hF);
        chk("rst_key_ready", kif_a.key_ready, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_fifo_count", cnt_a, 3'd0);
        chk("rst_pressed", pressed_a, 1'b0);
        chk("rst_key_cur", key_cur_a, 4'h0);
        chk("rst_fila_b", fila_b, 4'h0);
        rst = 1'b1;
        mon_en = 1'b1;
        tick();

        // single key 6, column sweep during the hold
        wait_idle_a(5);
        col_a = 4'b1111;
        push_a(4'h6);
        chk("t2_not_yet", pressed_a, 1'b0);
        tick();
        for (int i = 0; i < HOLD; i++) begin
            col_a = t2[i].col;
            #1;
            chk("t2_fila", fila_a, t2[i].fila);
            chk("t2_pressed", pressed_a, 1'b1);
            tick();
        end
        chk("t2_released", pressed_a, 1'b0);
        col_a = 4'b1011;
        #1;
        chk("t2_rel_fila", fila_a, 4'hF);

        // fill the queue, then offer a key while full
        wait_idle_a(20);
        rec_keys.delete(); rec_hi.delete();
        push_a(4'h0); push_a(4'h5); push_a(4'hA); push_a(4'hF);
        chk("t3_ready_3", kif_a.key_ready, 1'b1);
        chk("t3_count_3", cnt_a, 3'd3);
        push_a(4'h3);
        chk("t3_full_ready", kif_a.key_ready, 1'b0);
        chk("t3_full_count", cnt_a, 3'd4);
        kif_a.key_in = 4'h9; kif_a.key_valid = 1'b1;
        repeat (5) begin
            tick();
            chk("t3_full_hold", cnt_a, 3'd4);
        end
        kif_a.key_valid = 1'b0;
        wait_idle_a(100);
        chk("t3_nkeys", rec_keys.size(), 5);
        if (rec_keys.size() == 5) begin
            chk("t3_k0", rec_keys[0], 4'h0);
            chk("t3_k1", rec_keys[1], 4'h5);
            chk("t3_k2", rec_keys[2], 4'hA);
            chk("t3_k3", rec_keys[3], 4'hF);
            chk("t3_k4", rec_keys[4], 4'h3);
        end
        foreach (rec_hi[i]) chk("t3_hold_len", rec_hi[i], HOLD);

        // push and pop on the same edge with one entry queued in IDLE
        rec_keys.delete(); rec_hi.delete();
        push_a(4'h2);
        tick();
        chk("t4_first_press", pressed_a, 1'b1);
        push_a(4'h7);
        repeat (11) tick();
        chk("t4_idle_count", cnt_a, 3'd1);
        chk("t4_idle_pressed", pressed_a, 1'b0);
        chk("t4_idle_busy", busy_a, 1'b1);
        kif_a.key_in = 4'hC; kif_a.key_valid = 1'b1;
        tick();
        kif_a.key_valid = 1'b0;
        chk("t4_count_same", cnt_a, 3'd1);
        chk("t4_pressed", pressed_a, 1'b1);
        chk("t4_key_cur", key_cur_a, 4'h7);
        wait_idle_a(60);
        chk("t4_nkeys", rec_keys.size(), 3);
        if (rec_keys.size() == 3) begin
            chk("t4_k0", rec_keys[0], 4'h2);
            chk("t4_k1", rec_keys[1], 4'h7);
            chk("t4_k2", rec_keys[2], 4'hC);
        end

        // reset in the middle of a press with the column matching
        push_a(4'h6);
        tick();
        push_a(4'h9);
        col_a = 4'b1011;
        tick(); tick();
        #1;
        chk("t5_pre_fila", fila_a, 4'b1101);
        chk("t5_pre_count", cnt_a, 3'd1);
        rst = 1'b0;
        #1;
        chk("t5_fila", fila_a, 4'hF);
        chk("t5_pressed", pressed_a, 1'b0);
        chk("t5_count", cnt_a, 3'd0);
        chk("t5_busy", busy_a, 1'b0);
        tick();
        rst = 1'b1;
        begin
            int seen = 0;
            repeat (40) begin
                tick();
                if (pressed_a) seen++;
            end
            chk("t5_no_press", seen, 0);
        end

        // active-high instance, key F
        kif_b.key_in = 4'hF; kif_b.key_valid = 1'b1;
        tick();
        kif_b.key_valid = 1'b0;
        tick();
        for (int i = 0; i < HOLD; i++) begin
            col_b = t6[i].col;
            #1;
            chk("t6_fila", fila_b, t6[i].fila);
            tick();
        end
        chk("t6_released", pressed_b, 1'b0);

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            kif_a.key_valid = ($urandom_range(0, 5) == 0);
            kif_a.key_in    = 4'($urandom);
            if ($urandom_range(0, 1) == 0) col_a = ~(4'b0001 << $urandom_range(0, 3));
            else                           col_a = 4'($urandom);
            tick();
        end
        kif_a.key_valid = 1'b0;
        wait_idle_a(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
